lcd_refresh_ctrl: RTL and testbench

//  Drives a 16x2 HD44780 character LCD in 8-bit write-only mode, downstream of
//  lcd_display_string. Runs the power-on init sequence, then refreshes both

---
 rtl/lcd_refresh_ctrl.sv | 162 ++++++++++++++++
 tb/tb_lcd_refresh_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_refresh_ctrl.sv
// lcd_refresh_ctrl: drives a 16x2 HD44780 character LCD in 8-bit, write-only mode.
// After reset it waits out the LCD power-up time. It then sends function set,
// display on, entry mode and clear. After that it rewrites both lines forever:
// it sets the line-1 address, writes characters 0..15, sets the line-2 address
// and writes characters 16..31.
//
// Ports
//   clk        system clock
//   rst        asynchronous reset, active low
//   char_data  character code from the upstream string source, valid 1 clk after index moves
//   index      character position requested from the upstream string source
//   lcd_e      LCD enable strobe
//   lcd_rs     register select: 0 = command, 1 = data
//   lcd_rw     read/write select, tied to write (0)
//   lcd_data   LCD data bus DB7..DB0
//   frame_done one-clock pulse when the wait after the index-31 write expires
module lcd_refresh_ctrl #(
  parameter int unsigned PWR_WAIT  = 1_000_000,
  parameter int unsigned SETUP_CYC = 4,
  parameter int unsigned E_PULSE   = 25,
  parameter int unsigned CMD_WAIT  = 2_500,
  parameter int unsigned CLR_WAIT  = 100_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] char_data,
  output logic [4:0] index,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [7:0] lcd_data,
  output logic       frame_done
);

  localparam int unsigned XferMax = SETUP_CYC + E_PULSE + CLR_WAIT;
  localparam int unsigned CntMax  = (PWR_WAIT > XferMax) ? PWR_WAIT : XferMax;
  localparam int unsigned CntW    = $clog2(CntMax + 1);

  typedef enum logic [2:0] {
    StPwr, StFunc, StDisp, StEntry, StClr, StL1, StCh, StL2
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [4:0]      index_q, index_d;
  logic            lcd_e_q, lcd_e_d;
  logic            lcd_rs_q, lcd_rs_d;
  logic [7:0]      lcd_data_q, lcd_data_d;
  logic            frame_done_q, frame_done_d;
  logic            last_cyc;
  logic            xfer_d;

  function automatic logic [7:0] cmd_code(state_e st);
    logic [7:0] c;
    c = 8'h00;
    case (st)
      StFunc:  c = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
      StDisp:  c = 8'h0C;  // display on, cursor off
      StEntry: c = 8'h06;  // increment, no shift
      StClr:   c = 8'h01;
      StL1:    c = 8'h80;
      StL2:    c = 8'hC0;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  // Last cycle of the current transfer. Clear display needs the long wait.
  always_comb begin
    if (state_q == StClr) begin
      last_cyc = (cnt_q == CntW'(SETUP_CYC + E_PULSE + CLR_WAIT - 1));
    end else begin
      last_cyc = (cnt_q == CntW'(SETUP_CYC + E_PULSE + CMD_WAIT - 1));
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + CntW'(1);
    index_d      = index_q;
    frame_done_d = 1'b0;

    unique case (state_q)
      StPwr: begin
        if (cnt_q == CntW'(PWR_WAIT - 1)) begin
          state_d = StFunc;
          cnt_d   = '0;
        end
      end
      default: begin
        if (last_cyc) begin
          cnt_d = '0;
          unique case (state_q)
            StFunc:  state_d = StDisp;
            StDisp:  state_d = StEntry;
            StEntry: state_d = StClr;
            StClr:   state_d = StL1;
            StL1:    state_d = StCh;
            StL2:    state_d = StCh;
            StCh: begin
              if (index_q == 5'd15) begin
                state_d = StL2;
                index_d = 5'd16;
              end else if (index_q == 5'd31) begin
                state_d      = StL1;
                index_d      = 5'd0;
                frame_done_d = 1'b1;
              end else begin
                index_d = index_q + 5'd1;
              end
            end
            default: state_d = StPwr;
          endcase
        end
      end
    endcase
  end

  // Outputs are computed from the next state/phase so the registered values line up
  // with the phase counter: the value seen in cycle t is set at the edge entering t.
  always_comb begin
    xfer_d     = (state_d != StPwr);
    lcd_e_d    = xfer_d && (cnt_d >= CntW'(SETUP_CYC)) && (cnt_d < CntW'(SETUP_CYC + E_PULSE));
    lcd_rs_d   = lcd_rs_q;
    lcd_data_d = lcd_data_q;
    if (xfer_d && (cnt_d == CntW'(0))) begin
      lcd_rs_d = (state_d == StCh);
    end
    // index moved at t=0, so char_data has settled through t=1 before this capture.
    if (xfer_d && (cnt_d == CntW'(2))) begin
      lcd_data_d = (state_d == StCh) ? char_data : cmd_code(state_d);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StPwr;
      cnt_q        <= '0;
      index_q      <= 5'd0;
      lcd_e_q      <= 1'b0;
      lcd_rs_q     <= 1'b0;
      lcd_data_q   <= 8'h00;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      index_q      <= index_d;
      lcd_e_q      <= lcd_e_d;
      lcd_rs_q     <= lcd_rs_d;
      lcd_data_q   <= lcd_data_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign index      = index_q;
  assign lcd_e      = lcd_e_q;
  assign lcd_rs     = lcd_rs_q;
  assign lcd_rw     = 1'b0;
  assign lcd_data   = lcd_data_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_lcd_refresh_ctrl.sv
// Bench for lcd_refresh_ctrl: it models the upstream string source and records every
// E strobe. It compares the strobes with the expected init and frame sequences and
// checks the bus protocol on every cycle.
module tb_lcd_refresh_ctrl;

  localparam int unsigned PWR_WAIT  = 20;
  localparam int unsigned SETUP_CYC = 3;
  localparam int unsigned E_PULSE   = 2;
  localparam int unsigned CMD_WAIT  = 5;
  localparam int unsigned CLR_WAIT  = 12;
  localparam int          XFER      = SETUP_CYC + E_PULSE + CMD_WAIT;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] char_data = 8'h00;
  logic [4:0] index;
  logic       lcd_e, lcd_rs, lcd_rw, frame_done;
  logic [7:0] lcd_data;

  always #5 clk = ~clk;

  lcd_refresh_ctrl #(
    .PWR_WAIT (PWR_WAIT),
    .SETUP_CYC(SETUP_CYC),
    .E_PULSE  (E_PULSE),
    .CMD_WAIT (CMD_WAIT),
    .CLR_WAIT (CLR_WAIT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .char_data (char_data),
    .index     (index),
    .lcd_e     (lcd_e),
    .lcd_rs    (lcd_rs),
    .lcd_rw    (lcd_rw),
    .lcd_data  (lcd_data),
    .frame_done(frame_done)
  );

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  int rel_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Upstream string source: the time 12:34:56 on line 2, blanks elsewhere.
  logic [7:0] msg [32];
  initial begin
    logic [63:0] tm;
    tm = "12:34:56";
    for (int i = 0; i < 32; i++) msg[i] = 8'h20;
    for (int i = 0; i < 8; i++) msg[16+i] = tm[63-8*i -: 8];
  end

  // Registered char lookup. With glitch_en set it returns random values, except
  // when entering phases 1 and 2 of a refresh transfer. The phase is tracked from
  // index changes, which always land on a transfer start.
  bit         glitch_en = 1'b0;
  logic [4:0] idx_seen  = 5'd0;
  int         ph        = 0;
  always @(posedge clk) begin
    if (index != idx_seen) ph = 1;
    else ph = (ph + 1) % XFER;
    idx_seen = index;
    if (glitch_en && ph != 1 && ph != 2) char_data <= 8'($urandom);
    else char_data <= msg[index];
  end

  typedef struct {
    logic       rs;
    logic [7:0] data;
    logic [4:0] idx;
    int         c;
  } strobe_t;

  strobe_t    sq[$];
  int         widths[$];
  int         fd_cyc[$];
  int         fd_w[$];
  logic       e_prev = 1'b0, rs_prev = 1'b0, fd_prev = 1'b0;
  logic [7:0] d_prev = 8'h00;
  int         e_cnt = 0, fd_cnt = 0;

  // Strobe recorder and protocol checker.
  always @(negedge clk) begin
    if (rst) begin
      if (lcd_e && !e_prev) begin
        sq.push_back('{rs: lcd_rs, data: lcd_data, idx: index, c: cyc});
        e_cnt = 0;
      end
      if (lcd_e) e_cnt++;
      if (!lcd_e && e_prev) widths.push_back(e_cnt);
      if (frame_done && !fd_prev) begin
        fd_cyc.push_back(cyc);
        fd_cnt = 0;
      end
      if (frame_done) fd_cnt++;
      if (!frame_done && fd_prev) fd_w.push_back(fd_cnt);

      n_total++;
      if (lcd_rw !== 1'b0) $display("FAIL rw_low: lcd_rw=%b required 0 at cyc %0d", lcd_rw, cyc);
      else n_pass++;
      // In the rise cycle, the high cycles and the fall cycle, rs/data must hold the
      // values from the previous cycle.
      if (lcd_e || e_prev) begin
        n_total++;
        if (lcd_rs !== rs_prev || lcd_data !== d_prev)
          $display("FAIL bus_stable: rs/data=%b/%h required %b/%h at cyc %0d",
                   lcd_rs, lcd_data, rs_prev, d_prev, cyc);
        else n_pass++;
      end
    end
    e_prev  = lcd_e;
    rs_prev = lcd_rs;
    d_prev  = lcd_data;
    fd_prev = frame_done;
  end

  task automatic wait_strobes(input int n, input int budget, output bit ok);
    int k;
    k = 0;
    while (sq.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    #1;
    ok = (sq.size() >= n);
  endtask

  // Expected (rs, data, index) for position p of a refresh frame (0..33).
  function automatic logic [13:0] frame_exp(input int p);
    if (p == 0) return {1'b0, 8'h80, 5'd0};
    if (p <= 16) return {1'b1, msg[p-1], 5'(p-1)};
    if (p == 17) return {1'b0, 8'hC0, 5'd16};
    return {1'b1, msg[p-2], 5'(p-2)};
  endfunction

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if ({lcd_e, lcd_rs, lcd_rw, lcd_data, index, frame_done} !== 17'd0)
      $display("FAIL reset_outputs: e/rs/rw/data/idx/fd=%b/%b/%b/%h/%0d/%b required all 0",
               lcd_e, lcd_rs, lcd_rw, lcd_data, index, frame_done);
    else n_pass++;
    sq.delete(); widths.delete(); fd_cyc.delete(); fd_w.delete();
    @(negedge clk);
    rst = 1'b1;
    rel_cyc = cyc;
    for (int i = 0; i < int'(PWR_WAIT); i++) begin
      @(negedge clk);
      #1;
      n_total++;
      if ({lcd_e, lcd_rs, lcd_data, index, frame_done} !== 16'd0)
        $display("FAIL pwr_idle: e/rs/data/idx/fd=%b/%b/%h/%0d/%b required all 0 at clk %0d",
                 lcd_e, lcd_rs, lcd_data, index, frame_done, i);
      else n_pass++;
    end
  endtask

  task automatic test_init;
    bit         ok;
    logic [7:0] cmds [4];
    int         gaps [4];
    cmds = '{8'h38, 8'h0C, 8'h06, 8'h01};
    gaps = '{XFER, XFER, XFER, SETUP_CYC + E_PULSE + CLR_WAIT};
    wait_strobes(5, 400, ok);
    n_total++;
    if (!ok) begin
      $display("FAIL init_timeout: strobes=%0d required 5", sq.size());
      return;
    end
    n_pass++;
    n_total++;
    if (sq[0].c - rel_cyc != int'(PWR_WAIT + SETUP_CYC))
      $display("FAIL first_e_time: %0d required %0d", sq[0].c - rel_cyc, PWR_WAIT + SETUP_CYC);
    else n_pass++;
    n_total++;
    if (widths.size() < 1 || widths[0] != int'(E_PULSE))
      $display("FAIL e_width: %0d required %0d", (widths.size() > 0) ? widths[0] : -1, E_PULSE);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if ({sq[i].rs, sq[i].data} !== {1'b0, cmds[i]})
        $display("FAIL init_cmd%0d: rs/data=%b/%h required 0/%h", i, sq[i].rs, sq[i].data, cmds[i]);
      else n_pass++;
      n_total++;
      if (sq[i+1].c - sq[i].c != gaps[i])
        $display("FAIL init_gap%0d: %0d required %0d", i, sq[i+1].c - sq[i].c, gaps[i]);
      else n_pass++;
    end
  endtask

  // Checks one frame starting at strobe base, plus the following 0x80 strobe.
  task automatic test_frame(input int base, input string name);
    bit          ok;
    logic [13:0] exp;
    wait_strobes(base + 35, 34 * XFER + 200, ok);
    n_total++;
    if (!ok) begin
      $display("FAIL %s_timeout: strobes=%0d required %0d", name, sq.size(), base + 35);
      return;
    end
    n_pass++;
    for (int p = 0; p < 35; p++) begin
      exp = frame_exp(p % 34);
      n_total++;
      if ({sq[base+p].rs, sq[base+p].data, sq[base+p].idx} !== exp)
        $display("FAIL %s_strobe%0d: rs/data/idx=%b/%h/%0d required %b/%h/%0d", name, p,
                 sq[base+p].rs, sq[base+p].data, sq[base+p].idx, exp[13], exp[12:5], exp[4:0]);
      else n_pass++;
    end
  endtask

  task automatic test_frame_done(input int base);
    int n_fd, at, w, want;
    n_fd = 0; at = -1; w = -1;
    want = sq[base+33].c + int'(E_PULSE + CMD_WAIT);
    for (int i = 0; i < fd_cyc.size(); i++) begin
      if (fd_cyc[i] > sq[base].c && fd_cyc[i] <= sq[base+34].c) begin
        n_fd++;
        at = fd_cyc[i];
        if (i < fd_w.size()) w = fd_w[i];
      end
    end
    n_total++;
    if (n_fd != 1) $display("FAIL fd_count: %0d pulses required 1", n_fd);
    else n_pass++;
    n_total++;
    if (at != want) $display("FAIL fd_time: cyc %0d required %0d", at, want);
    else n_pass++;
    n_total++;
    if (w != 1) $display("FAIL fd_width: %0d required 1", w);
    else n_pass++;
  endtask

  task automatic test_glitch;
    bit ok;
    wait_strobes(38, 34 * XFER + 200, ok);
    glitch_en = 1'b1;
    test_frame(38, "glitch");
    test_frame_done(38);
    glitch_en = 1'b0;
  endtask

  task automatic test_reset_mid;
    bit ok;
    int k;
    k = 0;
    while (!(lcd_e && lcd_rs) && k < 200) begin
      @(negedge clk);
      k++;
    end
    n_total++;
    if (!(lcd_e && lcd_rs)) begin
      $display("FAIL mid_find_ch: no data strobe within %0d clks", k);
      return;
    end
    n_pass++;
    #2 rst = 1'b0;
    #1;
    n_total++;
    if ({lcd_e, lcd_rs, lcd_data, index, frame_done} !== 16'd0)
      $display("FAIL mid_reset: e/rs/data/idx/fd=%b/%b/%h/%0d/%b required all 0",
               lcd_e, lcd_rs, lcd_data, index, frame_done);
    else n_pass++;
    repeat (3) @(posedge clk);
    sq.delete(); widths.delete(); fd_cyc.delete(); fd_w.delete();
    @(negedge clk);
    rst = 1'b1;
    rel_cyc = cyc;
    wait_strobes(1, 200, ok);
    n_total++;
    if (!ok || {sq[0].rs, sq[0].data} !== {1'b0, 8'h38})
      $display("FAIL reinit_cmd: rs/data=%b/%h required 0/38",
               ok ? sq[0].rs : 1'bx, ok ? sq[0].data : 8'hxx);
    else n_pass++;
    n_total++;
    if (!ok || sq[0].c - rel_cyc != int'(PWR_WAIT + SETUP_CYC))
      $display("FAIL reinit_time: %0d required %0d", ok ? sq[0].c - rel_cyc : -1,
               PWR_WAIT + SETUP_CYC);
    else n_pass++;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_init();
    test_frame(4, "frame1");
    test_frame_done(4);
    test_glitch();
    test_reset_mid();
    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
